// File: rtl/chirp_frame_sequencer.sv
// chirp_frame_sequencer: drives an NCO through preamble upchirps, sync downchirps and symbol-offset data upchirps.
// Optional per-chirp watchdog enabled by defining CHIRP_TIMEOUT_EN.
module chirp_frame_sequencer #(
   parameter int PHASE_WIDTH  = 32,
   parameter int MAX_SF_WIDTH = 8,
   parameter int PREAMBLE_W   = 4,
   parameter int NUM_SYM_W    = 8,
   parameter int SYNC_CHIRPS  = 2
`ifdef CHIRP_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_frame_start_n,
   input  logic                    i_abort_n,
   input  logic [PREAMBLE_W-1:0]   i_preamble_len,
   input  logic [NUM_SYM_W-1:0]    i_num_syms,
   input  logic [PHASE_WIDTH-1:0]  i_base_inc,
   input  logic [PHASE_WIDTH-1:0]  i_sym_step,
   input  logic [PHASE_WIDTH-1:0]  i_slope,
   input  logic                    i_sym_valid,
   input  logic [MAX_SF_WIDTH-1:0] i_sym_data,
   output logic                    o_sym_ready,
   output logic                    o_nco_start_n,
   output logic [PHASE_WIDTH-1:0]  o_init_phase_inc,
   output logic [PHASE_WIDTH-1:0]  o_slope,
   input  logic                    i_nco_done_n,
   output logic                    o_busy,
   output logic                    o_frame_done_n,
   output logic                    o_err
);
   localparam int SW = (SYNC_CHIRPS > 1) ? $clog2(SYNC_CHIRPS) : 1;
   typedef enum logic [3:0] {
      IDLE, PRE_LAUNCH, PRE_WAIT, SYN_LAUNCH, SYN_WAIT, SYM_REQ, DAT_LAUNCH, DAT_WAIT, DONE
   } state_t;
   state_t state, state_nx;
   logic [PREAMBLE_W-1:0]  len_q, pre_cnt;
   logic [NUM_SYM_W-1:0]   num_q, sym_cnt;
   logic [SW-1:0]          syn_cnt;
   logic [PHASE_WIDTH-1:0] base_q, step_q, slope_q, base_src, slope_src;
   logic done, go, tmo, pre_last, syn_last, sym_last;

   assign done      = !i_nco_done_n;
   assign go        = state == IDLE && !i_frame_start_n && i_abort_n;
   assign pre_last  = pre_cnt == len_q - PREAMBLE_W'(1);
   assign syn_last  = syn_cnt == SW'(SYNC_CHIRPS - 1);
   assign sym_last  = sym_cnt == num_q - NUM_SYM_W'(1);
   // the first launch happens before the frame fields are latched
   assign base_src  = state == IDLE ? i_base_inc : base_q;
   assign slope_src = state == IDLE ? i_slope : slope_q;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (!i_abort_n) state_nx = IDLE;
      else
         case (state)
            IDLE:       if (!i_frame_start_n) state_nx = i_preamble_len != '0 ? PRE_LAUNCH : SYN_LAUNCH;
            PRE_LAUNCH: state_nx = PRE_WAIT;
            PRE_WAIT:   if (done) state_nx = pre_last ? SYN_LAUNCH : PRE_LAUNCH;
                        else if (tmo) state_nx = IDLE;
            SYN_LAUNCH: state_nx = SYN_WAIT;
            SYN_WAIT:   if (done) state_nx = !syn_last ? SYN_LAUNCH : num_q != '0 ? SYM_REQ : DONE;
                        else if (tmo) state_nx = IDLE;
            SYM_REQ:    if (i_sym_valid) state_nx = DAT_LAUNCH;
            DAT_LAUNCH: state_nx = DAT_WAIT;
            DAT_WAIT:   if (done) state_nx = sym_last ? DONE : SYM_REQ;
                        else if (tmo) state_nx = IDLE;
            default:    state_nx = IDLE;
         endcase
   end

   always_comb begin
      o_nco_start_n  = !(state inside {PRE_LAUNCH, SYN_LAUNCH, DAT_LAUNCH});
      o_sym_ready    = state == SYM_REQ;
      o_busy         = state != IDLE;
      o_frame_done_n = state != DONE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         len_q            <= '0;
         num_q            <= '0;
         base_q           <= '0;
         step_q           <= '0;
         slope_q          <= '0;
         pre_cnt          <= '0;
         syn_cnt          <= '0;
         sym_cnt          <= '0;
         o_init_phase_inc <= '0;
         o_slope          <= '0;
      end else begin
         if (go) begin
            len_q   <= i_preamble_len;
            num_q   <= i_num_syms;
            base_q  <= i_base_inc;
            step_q  <= i_sym_step;
            slope_q <= i_slope;
            pre_cnt <= '0;
            syn_cnt <= '0;
            sym_cnt <= '0;
         end
         if (state_nx == PRE_LAUNCH) begin
            o_init_phase_inc <= base_src;
            o_slope          <= slope_src;
         end
         if (state_nx == SYN_LAUNCH) begin
            o_init_phase_inc <= base_src;
            o_slope          <= ~slope_src + PHASE_WIDTH'(1);
         end
         if (state_nx == DAT_LAUNCH) begin
            o_init_phase_inc <= base_q + step_q * PHASE_WIDTH'(i_sym_data);
            o_slope          <= slope_q;
         end
         if (state == PRE_WAIT && state_nx == PRE_LAUNCH) pre_cnt <= pre_cnt + PREAMBLE_W'(1);
         if (state == SYN_WAIT && state_nx == SYN_LAUNCH) syn_cnt <= syn_cnt + SW'(1);
         if (state == DAT_WAIT && state_nx == SYM_REQ) sym_cnt <= sym_cnt + NUM_SYM_W'(1);
      end

`ifdef CHIRP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_cnt;
   logic          err_q, waiting;
   assign waiting = state inside {PRE_WAIT, SYN_WAIT, DAT_WAIT};
   assign tmo     = waiting && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign o_err   = err_q;
   // every WAIT is entered from a LAUNCH, so clearing outside WAIT restarts it per chirp
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= waiting ? wd_cnt + TW'(1) : '0;
         if (go) err_q <= 1'b0;
         else if (tmo && !done && i_abort_n) err_q <= 1'b1;
      end
`else
   assign tmo   = 1'b0;
   assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_chirp_frame_sequencer.sv
// tb_chirp_frame_sequencer: scoreboard bench with a fixed-latency NCO model and a symbol source.
`timescale 1ns/1ps
module tb_chirp_frame_sequencer;
   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_frame_start_n = 1'b1, i_abort_n = 1'b1;
   logic [3:0]  i_preamble_len = '0;
   logic [7:0]  i_num_syms = '0, i_sym_data = '0;
   logic [31:0] i_base_inc = '0, i_sym_step = '0, i_slope = '0;
   logic        i_sym_valid = 1'b0, i_nco_done_n = 1'b1;
   logic        o_sym_ready, o_nco_start_n, o_busy, o_frame_done_n, o_err;
   logic [31:0] o_init_phase_inc, o_slope;

   int errs = 0, checks = 0;
   int starts = 0, frame_dones = 0, ready_viol = 0, nco_cnt = 0, nco_delay = 10;
   bit nco_mute = 0;
   logic [31:0] exp_init[$], exp_slope[$];

   chirp_frame_sequencer #(
      .SYNC_CHIRPS(2)
`ifdef CHIRP_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start_n(i_frame_start_n), .i_abort_n(i_abort_n),
      .i_preamble_len(i_preamble_len), .i_num_syms(i_num_syms), .i_base_inc(i_base_inc),
      .i_sym_step(i_sym_step), .i_slope(i_slope), .i_sym_valid(i_sym_valid), .i_sym_data(i_sym_data),
      .o_sym_ready(o_sym_ready), .o_nco_start_n(o_nco_start_n), .o_init_phase_inc(o_init_phase_inc),
      .o_slope(o_slope), .i_nco_done_n(i_nco_done_n), .o_busy(o_busy), .o_frame_done_n(o_frame_done_n),
      .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] init, input logic [31:0] slope);
      exp_init.push_back(init);
      exp_slope.push_back(slope);
   endtask

   // NCO model and scoreboard: every start pulse pops the expected init/slope
   initial forever begin
      @(negedge i_clk);
      i_nco_done_n = 1'b1;
      if (nco_cnt > 0) begin
         nco_cnt--;
         if (nco_cnt == 0) i_nco_done_n = 1'b0;
      end
      if (i_rst_n && !o_nco_start_n) begin
         starts++;
         if (exp_init.size() == 0) check("start_unexpected", 32'd1, 32'd0);
         else begin
            check("init", o_init_phase_inc, exp_init.pop_front());
            check("slope", o_slope, exp_slope.pop_front());
         end
         if (!nco_mute) nco_cnt = nco_delay;
      end
      if (o_sym_ready && (nco_cnt != 0 || !o_nco_start_n)) ready_viol++;
      if (!o_frame_done_n) frame_dones++;
   end

   task automatic frame(input logic [3:0] len, input logic [7:0] num, input logic [31:0] base,
                        input logic [31:0] step, input logic [31:0] slope);
      @(negedge i_clk);
      starts = 0;
      frame_dones = 0;
      ready_viol = 0;
      i_preamble_len = len;
      i_num_syms = num;
      i_base_inc = base;
      i_sym_step = step;
      i_slope = slope;
      i_frame_start_n = 1'b0;
      @(negedge i_clk);
      i_frame_start_n = 1'b1;
      check("busy_rise", o_busy, 1'b1);
   endtask

   task automatic wait_ready(input int limit);
      int n = 0;
      while (!o_sym_ready && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check("ready_wait_bound", n < limit, 1'b1);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (o_busy && n < limit) begin
         @(negedge i_clk);
         n++;
      end
      check("idle_wait_bound", n < limit, 1'b1);
   endtask

   task automatic send_sym(input logic [7:0] s, input logic [31:0] base, input logic [31:0] step,
                           input logic [31:0] slope);
      wait_ready(200);
      push(base + step * {24'd0, s}, slope);
      i_sym_valid = 1'b1;
      i_sym_data = s;
      @(negedge i_clk);
      i_sym_valid = 1'b0;
   endtask

   initial begin
      int busy_cnt, s0, n;
      // 1: reset state
      #23 i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rst_start_n", o_nco_start_n, 1'b1);
      check("rst_done_n", o_frame_done_n, 1'b1);
      check("rst_init", o_init_phase_inc, 32'h0);
      check("rst_slope", o_slope, 32'h0);
      check("rst_ready", o_sym_ready, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_err", o_err, 1'b0);
      busy_cnt = 0;
      repeat (20) begin
         @(negedge i_clk);
         if (o_busy) busy_cnt++;
      end
      check("idle_busy_cycles", busy_cnt, 0);

      // 2: preamble + sync, no data
      push(32'h1000, 32'h100);
      push(32'h1000, 32'h100);
      push(32'h1000, 32'hFFFF_FF00);
      push(32'h1000, 32'hFFFF_FF00);
      frame(4'd2, 8'd0, 32'h1000, 32'h0, 32'h100);
      wait_idle(300);
      @(negedge i_clk);
      check("t2_starts", starts, 4);
      check("t2_frame_dones", frame_dones, 1);
      check("t2_queue_left", exp_init.size(), 0);

      // 3: no preamble, three data symbols including the maximum value
      push(32'h1000, 32'hFFFF_FF00);
      push(32'h1000, 32'hFFFF_FF00);
      frame(4'd0, 8'd3, 32'h1000, 32'h10, 32'h100);
      send_sym(8'd0, 32'h1000, 32'h10, 32'h100);
      send_sym(8'd5, 32'h1000, 32'h10, 32'h100);
      send_sym(8'd255, 32'h1000, 32'h10, 32'h100);
      wait_idle(300);
      @(negedge i_clk);
      check("t3_starts", starts, 5);
      check("t3_frame_dones", frame_dones, 1);
      check("t3_ready_outside_req", ready_viol, 0);
      check("t3_data_last", 32'h1000 + 32'h10 * 32'd255, 32'h1FF0);

      // 4: symbol stall then launch latency
      push(32'h2000, 32'hFFFF_FF80);
      push(32'h2000, 32'hFFFF_FF80);
      frame(4'd0, 8'd1, 32'h2000, 32'h4, 32'h80);
      wait_ready(200);
      s0 = starts;
      repeat (50) @(negedge i_clk);
      check("t4_stall_starts", starts, s0);
      check("t4_stall_busy", o_busy, 1'b1);
      check("t4_stall_ready", o_sym_ready, 1'b1);
      push(32'h201C, 32'h80);
      i_sym_valid = 1'b1;
      i_sym_data = 8'd7;
      @(negedge i_clk);
      i_sym_valid = 1'b0;
      check("t4_launch_latency", o_nco_start_n, 1'b0);
      wait_idle(300);
      @(negedge i_clk);
      check("t4_frame_dones", frame_dones, 1);

      // 5: abort in the second preamble wait, colliding with done
      for (int i = 0; i < 3; i++) push(32'h3000, 32'h40);
      push(32'h3000, 32'hFFFF_FFC0);
      push(32'h3000, 32'hFFFF_FFC0);
      frame(4'd3, 8'd0, 32'h3000, 32'h0, 32'h40);
      n = 0;
      while (starts < 2 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      check("t5_second_start_bound", n < 200, 1'b1);
      n = 0;
      do begin
         @(negedge i_clk);
         #1;
         n++;
      end while (i_nco_done_n && n < 50);
      check("t5_done_seen", i_nco_done_n, 1'b0);
      i_abort_n = 1'b0;
      @(negedge i_clk);
      i_abort_n = 1'b1;
      check("t5_abort_busy", o_busy, 1'b0);
      check("t5_abort_start_n", o_nco_start_n, 1'b1);
      check("t5_abort_ready", o_sym_ready, 1'b0);
      repeat (30) @(negedge i_clk);
      check("t5_abort_starts", starts, 2);
      check("t5_abort_no_done", frame_dones, 0);
      exp_init.delete();
      exp_slope.delete();
      push(32'h1000, 32'h100);
      push(32'h1000, 32'hFFFF_FF00);
      push(32'h1000, 32'hFFFF_FF00);
      frame(4'd1, 8'd1, 32'h1000, 32'h10, 32'h100);
      send_sym(8'd3, 32'h1000, 32'h10, 32'h100);
      wait_idle(300);
      @(negedge i_clk);
      check("t5_recover_starts", starts, 4);
      check("t5_recover_dones", frame_dones, 1);
      check("t5_recover_queue", exp_init.size(), 0);

      // 6: NCO never answers, then async reset mid-frame
      nco_mute = 1;
      push(32'h500, 32'h20);
      frame(4'd1, 8'd0, 32'h500, 32'h0, 32'h20);
      repeat (150) @(negedge i_clk);
`ifdef CHIRP_TIMEOUT_EN
      check("t6_err", o_err, 1'b1);
      check("t6_idle", o_busy, 1'b0);
`else
      check("t6_err", o_err, 1'b0);
      check("t6_still_wait", o_busy, 1'b1);
`endif
      check("t6_starts", starts, 1);
      check("t6_frame_dones", frame_dones, 0);
      frame(4'd1, 8'd0, 32'h700, 32'h0, 32'h30);
      #2 i_rst_n = 1'b0;
      #1;
      check("t6_rst_busy", o_busy, 1'b0);
      check("t6_rst_start_n", o_nco_start_n, 1'b1);
      check("t6_rst_init", o_init_phase_inc, 32'h0);
      check("t6_rst_slope", o_slope, 32'h0);
      check("t6_rst_err", o_err, 1'b0);
      exp_init.delete();
      exp_slope.delete();
      nco_mute = 0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
